// File: rtl/fpnew_pkg.sv
`default_nettype none
// ============================================================================
// fpnew_pkg : shared FPU types (IEEE status flags) and flag-merge helper
// Revision  : 1.0
// ============================================================================
package fpnew_pkg;

  typedef struct packed {
    logic NV;  // invalid operation
    logic DZ;  // divide by zero
    logic OF;  // overflow
    logic UF;  // underflow
    logic NX;  // inexact
  } status_t;

  localparam int unsigned NumStatusBits = $bits(status_t);

  function automatic status_t status_merge(input status_t a, input status_t b);
    status_t r;
    r = a | b;
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpnew_rq_storage.sv
`default_nettype none
// ============================================================================
// fpnew_rq_storage : Depth x DataWidth register array, one write port and an
//                    asynchronous read port; data is not reset
// Revision         : 1.0
// ============================================================================
module fpnew_rq_storage #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 77,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/fpnew_result_queue.sv
`default_nettype none
// ============================================================================
// fpnew_result_queue : FIFO between FPU result handshake and core writeback,
//                      with sticky fflags accumulated on retirement
// Revision           : 1.0
// ============================================================================
module fpnew_result_queue
  import fpnew_pkg::*;
#(
  parameter  int unsigned Width      = 64,
  parameter  int unsigned Depth      = 4,
  parameter  int unsigned TagWidth   = 8,
  localparam int unsigned CountWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic [Width-1:0]      in_result_i,
  input  status_t               in_status_i,
  input  logic [TagWidth-1:0]   in_tag_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [Width-1:0]      out_result_o,
  output status_t               out_status_o,
  output logic [TagWidth-1:0]   out_tag_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output status_t               fflags_o,
  input  logic                  fflags_clr_i,
  output logic [CountWidth-1:0] count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned AddrWidth = $clog2(Depth);
  localparam logic [CountWidth-1:0] DepthCnt = CountWidth'(Depth);

  typedef struct packed {
    logic [Width-1:0]    result;
    status_t             status;
    logic [TagWidth-1:0] tag;
  } rq_entry_t;

  rq_entry_t             wdata, rdata;
  logic [AddrWidth-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CountWidth-1:0] count_q, count_d;
  status_t               fflags_q, fflags_d;
  logic                  push, pop;

  // Full/empty come from the count so pointer equality is never ambiguous.
  assign full_o      = (count_q == DepthCnt);
  assign empty_o     = (count_q == '0);
  assign in_ready_o  = !full_o;
  assign out_valid_o = !empty_o;
  assign count_o     = count_q;
  assign fflags_o    = fflags_q;

  assign push = in_valid_i & in_ready_o & ~flush_i;
  assign pop  = out_valid_o & out_ready_i & ~flush_i;

  assign wdata.result = in_result_i;
  assign wdata.status = in_status_i;
  assign wdata.tag    = in_tag_i;

  fpnew_rq_storage #(
    .Depth     (Depth),
    .DataWidth ($bits(rq_entry_t)),
    .AddrWidth (AddrWidth)
  ) i_storage (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wdata),
    .raddr_i (rptr_q),
    .rdata_o (rdata)
  );

  assign out_result_o = rdata.result;
  assign out_status_o = rdata.status;
  assign out_tag_o    = rdata.tag;

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    // Clear applies first so a retiring entry in the same cycle still lands.
    fflags_d = fflags_clr_i ? '0 : fflags_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + AddrWidth'(1);
      end
      if (pop) begin
        rptr_d   = rptr_q + AddrWidth'(1);
        fflags_d = status_merge(fflags_d, rdata.status);
      end
      count_d = count_q + CountWidth'(push) - CountWidth'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      fflags_q <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      fflags_q <= fflags_d;
    end
  end

  a_count_le_depth: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= DepthCnt);
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(pop && count_q == '0));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push && !pop && count_q == DepthCnt));

endmodule
`default_nettype wire

// File: tb/tb_fpnew_result_queue.sv
`default_nettype none
// ============================================================================
// tb_fpnew_result_queue : directed self-checking bench for fpnew_result_queue
// Revision              : 1.0
// ============================================================================
module tb_fpnew_result_queue;
  import fpnew_pkg::*;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        flush     = 1'b0;
  logic [63:0] in_result = '0;
  status_t     in_status = '0;
  logic [7:0]  in_tag    = '0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic        clr       = 1'b0;
  logic        in_ready, out_valid, full, empty;
  logic [63:0] out_result;
  status_t     out_status, fflags;
  logic [7:0]  out_tag;
  logic [2:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  fpnew_result_queue #(.Width(64), .Depth(4), .TagWidth(8)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .flush_i      (flush),
    .in_result_i  (in_result),
    .in_status_i  (in_status),
    .in_tag_i     (in_tag),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .out_result_o (out_result),
    .out_status_o (out_status),
    .out_tag_o    (out_tag),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .fflags_o     (fflags),
    .fflags_clr_i (clr),
    .count_o      (count),
    .full_o       (full),
    .empty_o      (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] r, input logic [4:0] s, input logic [7:0] t);
    in_result = r;
    in_status = s;
    in_tag    = t;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fflags", fflags, 0);
    rst_n = 1'b1;
    tick();

    // Single op
    push_one(64'h3FF0000000000000, 5'b00001, 8'h12);
    check("single_valid", out_valid, 1);
    check("single_result", out_result, 64'h3FF0000000000000);
    check("single_status", out_status, 5'b00001);
    check("single_tag", out_tag, 8'h12);
    check("single_count", count, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_fflags", fflags, 5'b00001);
    check("single_empty", empty, 1);

    // Fill, hold fifth, pop once, accept fifth, drain in order
    for (int t = 1; t <= 4; t++) push_one(64'(t) << 8, 5'b00000, 8'(t));
    check("fill_full", full, 1);
    check("fill_count", count, 4);
    check("fill_in_ready", in_ready, 0);
    check("fill_head", out_tag, 1);
    in_tag   = 8'd5;
    in_valid = 1'b1;
    tick();
    check("held_count", count, 4);
    check("held_head", out_tag, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_full_count", count, 3);
    check("pop_full_in_ready", in_ready, 1);
    check("pop_full_head", out_tag, 2);
    tick();
    in_valid = 1'b0;
    check("accept5_count", count, 4);
    check("accept5_full", full, 1);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_order", out_tag, 64'(i));
      tick();
    end
    out_ready = 1'b0;
    check("drain_empty", empty, 1);

    // Continuous push and pop across pointer wrap
    out_ready = 1'b1;
    in_status = '0;
    for (int i = 0; i < 10; i++) begin
      in_tag   = 8'(8'h20 + i);
      in_valid = 1'b1;
      tick();
      check("stream_count", count, 1);
      check("stream_tag", out_tag, 64'(8'h20 + i));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    check("stream_empty", empty, 1);
    check("stream_fflags", fflags, 5'b00001);

    // Sticky flags
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_alone", fflags, 5'b00000);
    push_one(64'h1, 5'b00100, 8'h31);
    push_one(64'h2, 5'b01000, 8'h32);
    check("no_flags_at_push", fflags, 5'b00000);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    check("sticky_of_dz", fflags, 5'b01100);
    push_one(64'h3, 5'b10000, 8'h33);
    out_ready = 1'b1;
    clr       = 1'b1;
    tick();
    out_ready = 1'b0;
    clr       = 1'b0;
    check("clr_with_pop", fflags, 5'b10000);
    check("clr_with_pop_empty", empty, 1);

    // Flush with concurrent push
    clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) push_one(64'(i), 5'b10000, 8'(8'h60 + i));
    check("preflush_count", count, 3);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 8'h99;
    in_status = 5'b00010;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_count", count, 0);
    check("flush_valid", out_valid, 0);
    check("flush_fflags", fflags, 5'b00000);
    tick();
    check("flush_discard", empty, 1);

    // Asynchronous reset mid-cycle
    push_one(64'h4, 5'b00100, 8'h40);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pre_rst_fflags", fflags, 5'b00100);
    push_one(64'h5, 5'b00000, 8'h41);
    push_one(64'h6, 5'b00000, 8'h42);
    check("pre_rst_count", count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    check("arst_full", full, 0);
    check("arst_valid", out_valid, 0);
    check("arst_in_ready", in_ready, 1);
    check("arst_fflags", fflags, 0);
    #1;
    rst_n = 1'b1;
    tick();
    push_one(64'hDEAD_BEEF_0000_0001, 5'b00000, 8'h55);
    check("post_rst_count", count, 1);
    check("post_rst_tag", out_tag, 8'h55);
    check("post_rst_result", out_result, 64'hDEAD_BEEF_0000_0001);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_rst_empty", empty, 1);
    check("post_rst_fflags", fflags, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpnew_result_queue.md
Name: fpnew_result_queue

Overview:
- Output-side buffer placed directly downstream of the FPU top-level result handshake (result/status/tag, valid/ready).
- Decouples FPU retirement from the core writeback port so FPU pipelines are never back-pressured by short writeback stalls.
- Accumulates sticky IEEE exception flags (fflags) on retirement.
- Reports occupancy so issue logic can gate dispatch.

Parameters:
- Width, 64, result width in bits; must equal the FPU datapath width.
- Depth, 4, number of entries; power of two, at least 2.
- TagWidth, 8, width of the opaque tag carried with each result.
- CountWidth, $clog2(Depth+1), derived (localparam); width of count_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of all queued entries
- in_result_i  in  Width  FPU result
- in_status_i  in  5  fpnew_pkg::status_t {NV,DZ,OF,UF,NX}
- in_tag_i  in  TagWidth  tag of the result
- in_valid_i  in  1  FPU output valid
- in_ready_o  out  1  queue can accept a result
- out_result_o  out  Width  head entry result
- out_status_o  out  5  head entry status
- out_tag_o  out  TagWidth  head entry tag
- out_valid_o  out  1  head entry valid
- out_ready_i  in  1  writeback accepts head
- fflags_o  out  5  sticky accumulated exception flags
- fflags_clr_i  in  1  clear sticky flags (CSR write)
- count_o  out  CountWidth  current occupancy
- full_o  out  1  count_o == Depth
- empty_o  out  1  count_o == 0

Behaviour:
- Reset values (asynchronous, rst_ni low):
  - read/write pointers, count_o, fflags_o = 0
  - empty_o = 1; full_o = 0; out_valid_o = 0; in_ready_o = 1
  - storage contents undefined; out_* data outputs are don't-care while out_valid_o = 0.
- Push: in_valid_i & in_ready_o on a clock edge. Entry is written at wptr; wptr increments mod Depth.
- Pop: out_valid_o & out_ready_i on a clock edge. rptr increments mod Depth.
- Latency: no fall-through. An entry pushed at edge N is visible on out_* with out_valid_o = 1 in the cycle after edge N, so minimum latency is 1 cycle.
- Output timing:
  - out_* are driven from registered storage at rptr.
  - out_valid_o = !empty_o.
  - in_ready_o = !full_o. It does not depend on out_ready_i, so there is no combinational ready path.
- Ordering: strict FIFO order; results retire in the order accepted.
- Simultaneous push and pop while not full and not empty: count unchanged, both pointers advance.
- Full: in_ready_o = 0. A push is not accepted in the same cycle as a pop while full; in_ready_o rises the cycle after the pop.
- Empty: out_valid_o = 0; out_ready_i is ignored.
- Count: count_o += push, -= pop. It never exceeds Depth and never underflows; assertions are required on both.
- Pointer wrap: Depth-1 -> 0. Full/empty are derived from count, not from pointer equality.
- fflags accumulation:
  - On each pop: fflags_o <= fflags_o | out_status_o.
  - Accumulation happens at retirement, not at push, so flushed results never set flags.
- fflags_clr_i:
  - Alone: fflags_o <= 0.
  - Same cycle as a pop: fflags_o <= out_status_o (clear first, then OR in the retiring entry).
- flush_i, highest priority:
  - Pointers and count go to 0 at the next edge; any push or pop in that cycle is discarded.
  - fflags_o is unaffected; fflags_clr_i is still honoured in that cycle.
  - out_valid_o = 0 the cycle after flush.
- Reset mid-operation: all state is lost immediately, with no partial retirement.
- Handshake stability: once out_valid_o is asserted, out_* stay stable until popped or flushed.

Decomposition:
- fpnew_pkg: use the existing status_t. Add the typedef rq_entry_t {result, status, tag}, parameterised via the module's local typedef since its widths are module parameters.
- Sub-module fpnew_rq_storage: Depth x entry register array with write port (we, waddr, wdata) and asynchronous read port (raddr). It has no reset on data.
- Top-level fpnew_result_queue holds pointers, count, flush logic and fflags.

Test Plan:
- Single op: push result 0x3FF0000000000000, status NX, tag 0x12 -> next cycle out_valid_o = 1 with the same values; pop with out_ready_i = 1 -> fflags_o = 5'b00001, empty_o = 1.
- Fill: out_ready_i = 0, push tags 1..4 -> full_o = 1, count_o = 4, in_ready_o = 0; a 5th valid is held. Pop once -> in_ready_o = 1 the next cycle; the held tag 5 is accepted. Drain order is 1, 2, 3, 4, 5.
- Wrap and simultaneous: continuous push and pop with out_ready_i = 1 over 10 results -> count_o stays at 1 after the first; tags emerge in order across pointer wrap.
- Sticky flags: retire statuses OF then DZ -> fflags_o = 5'b01100 (OF|DZ); fflags_clr_i in the same cycle as popping an NV entry -> fflags_o = 5'b10000.
- Flush: 3 queued entries with status NV, assert flush_i together with a push -> next cycle count_o = 0, out_valid_o = 0, fflags_o unchanged, and the pushed entry is discarded.
- Async reset: assert rst_ni low mid-cycle with 2 entries queued -> outputs reach reset values immediately; after release, the first push appears as the sole entry.
